multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Parametrised multi-cycle control unit for the RISC-V datapath. It replaces the single-cycle opcode decoder plus ALU-control pair.
- A Moore FSM sequences each instruction through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK and drives datapath enables, mux selects and the 4-bit ALU Operation.
- It supports a configurable memory latency, detects illegal instructions and counts retired instructions.

Parameters:
- MEM_LAT, 1, cycles each memory access (FETCH, MEM_RD, MEM_WR) is held; legal range 1..15.
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- Opcode  input  7  instr[6:0], from the instruction register.
- Funct  input  4  {instr[30], instr[14:12]}.
- Zero  input  1  ALU zero flag.
- PCWrite  output  1  PC load enable (unconditional or taken branch).
- IRWrite  output  1  instruction register load.
- MemRead  output  1  memory read strobe.
- MemWrite  output  1  memory write strobe.
- MemtoReg  output  1  1 = writeback from MDR, 0 = from ALUOut.
- RegWrite  output  1  register-file write enable.
- ALUSrcA  output  1  0 = PC, 1 = rs1.
- ALUSrcB  output  2  0 = rs2, 1 = const 4, 2 = imm.
- PCSource  output  1  0 = ALU result, 1 = ALUOut register.
- Operation  output  4  ALU operation: 0010 ADD, 0110 SUB, 0000 AND, 0001 OR.
- illegal  output  1  sticky illegal-instruction flag.
- instr_count  output  CNT_W  retired-instruction count.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, wait counter=0, illegal=0, instr_count=0.
  - IDLE drives all outputs to 0, Operation=0010.
  - IDLE moves to FETCH on the first clock after reset is released.
- Reset asserted mid-instruction: immediate return to IDLE. No partial strobes are held and the counter is not incremented.
- States and outputs. Unlisted outputs are 0 and Operation=0010 unless stated.
  - FETCH: MemRead=1, ALUSrcA=0, ALUSrcB=1. Held MEM_LAT cycles by the wait counter. IRWrite=1 and PCWrite=1 in the last cycle only. Next state: DECODE.
  - DECODE: ALUSrcA=0, ALUSrcB=2 (branch target into ALUOut). Next state by Opcode:
    - 0110011 -> EXEC_R
    - 0010011 -> EXEC_I
    - 0000011 or 0100011 -> MEM_ADDR
    - 1100011 -> BRANCH
    - any other value -> FETCH, with illegal set.
  - Illegal Funct also goes to FETCH with illegal set:
    - R-type: Funct not in {0000, 1000, 0111, 0110}.
    - I-type: Funct[2:0] not in {000, 111, 110}.
  - EXEC_R: ALUSrcA=1, ALUSrcB=0. Operation from Funct: 0000 ADD, 1000 SUB, 0111 AND, 0110 OR. Next state: ALU_WB.
  - EXEC_I: ALUSrcA=1, ALUSrcB=2. Funct[3] is ignored; Funct[2:0] 000 ADD, 111 AND, 110 OR. Next state: ALU_WB.
  - ALU_WB: RegWrite=1, MemtoReg=0. Next state: FETCH (retire).
  - MEM_ADDR: ALUSrcA=1, ALUSrcB=2, ADD. Next state: MEM_RD for a load, MEM_WR for a store.
  - MEM_RD: MemRead=1, held MEM_LAT cycles. Next state: MEM_WB.
  - MEM_WB: RegWrite=1, MemtoReg=1. Next state: FETCH (retire).
  - MEM_WR: MemWrite=1, held MEM_LAT cycles. Next state: FETCH (retire), leaving after the last cycle.
  - BRANCH: ALUSrcA=1, ALUSrcB=0, SUB, PCSource=1. PCWrite=Zero (combinational). Next state: FETCH (retire), whether taken or not.
- Latency in cycles, with M=MEM_LAT: R/I = M+3, LW = 2M+3, SW = 2M+2, BEQ = M+2, illegal = M+1.
- Wait counter: 4 bits, loaded 0 on entering a memory state, increments each cycle. Exit when it equals MEM_LAT-1. With MEM_LAT=1 each memory state lasts exactly one cycle.
- instr_count:
  - Increments by 1 on each retiring transition into FETCH.
  - Does not increment on IDLE->FETCH or on illegal->FETCH.
  - Wraps modulo 2^CNT_W with no saturation.
- illegal: set on the DECODE cycle that detects the fault and stays set until reset. Execution continues with the next fetch.
- Opcode and Funct are sampled only in DECODE, EXEC_R and EXEC_I. They are don't-care elsewhere.

Test Plan:
- Reset, then add (Opcode=0110011, Funct=0000), MEM_LAT=1: FETCH asserts MemRead/IRWrite/PCWrite. EXEC_R drives Operation=0010. ALU_WB asserts RegWrite=1, MemtoReg=0. instr_count=1 after 4 cycles.
- lw (0000011) with MEM_LAT=3: FETCH held 3 cycles, with IRWrite only on the 3rd. MEM_RD held 3 cycles. MEM_WB asserts RegWrite=1, MemtoReg=1. Total 9 cycles.
- beq (1100011) with Zero=1: BRANCH asserts Operation=0110, PCSource=1, PCWrite=1. Repeat with Zero=0: PCWrite=0. Both retire in 3 cycles (MEM_LAT=1).
- sw (0100011): MEM_WR asserts MemWrite=1, RegWrite stays 0 throughout, 4 cycles.
- Illegal Opcode=1111111, then R-type Funct=0001: illegal=1 after the first DECODE. FSM returns to FETCH and instr_count does not change. illegal stays 1 through following legal instructions.
- Assert reset=0 in MEM_RD: all outputs are 0 asynchronously and instr_count=0. After release, the first FETCH starts exactly one cycle later. Also preload instr_count to 2^CNT_W-1 via instructions and check it wraps to 0.

Source files
------------

// File: rtl/multicycle_control.sv
// multicycle_control: Moore FSM sequencing RISC-V instructions through fetch/decode/execute/memory/writeback,
// with configurable memory latency, sticky illegal-instruction flag and retired-instruction counter.
module multicycle_control #(
    parameter int MEM_LAT = 1,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       Opcode,
    input  logic [3:0]       Funct,
    input  logic             Zero,
    output logic             PCWrite,
    output logic             IRWrite,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             MemtoReg,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic             PCSource,
    output logic [3:0]       Operation,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_count
);
    typedef enum logic [3:0] {
        IDLE, FETCH, DECODE, EXEC_R, EXEC_I, ALU_WB, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, BRANCH
    } state_t;

    localparam logic [3:0] LAST = 4'(MEM_LAT - 1);

    state_t     state, next, dec_next;
    logic [3:0] wait_cnt;
    logic       mem_done, is_store, r_ok, i_ok, retire;

    assign mem_done = wait_cnt == LAST;
    assign r_ok     = Funct inside {4'b0000, 4'b1000, 4'b0111, 4'b0110};
    assign i_ok     = Funct[2:0] inside {3'b000, 3'b111, 3'b110};
    assign retire   = next == FETCH && state inside {ALU_WB, MEM_WB, MEM_WR, BRANCH};

    always_comb begin
        dec_next = FETCH;
        case (Opcode)
            7'b0110011:             dec_next = r_ok ? EXEC_R : FETCH;
            7'b0010011:             dec_next = i_ok ? EXEC_I : FETCH;
            7'b0000011, 7'b0100011: dec_next = MEM_ADDR;
            7'b1100011:             dec_next = BRANCH;
            default:                dec_next = FETCH;
        endcase
    end

    always_comb begin
        next      = state;
        PCWrite   = 1'b0;
        IRWrite   = 1'b0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        MemtoReg  = 1'b0;
        RegWrite  = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 2'd0;
        PCSource  = 1'b0;
        Operation = 4'b0010;
        case (state)
            IDLE:   next = FETCH;
            FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'd1;
                IRWrite = mem_done;
                PCWrite = mem_done;
                next    = mem_done ? DECODE : FETCH;
            end
            DECODE: begin
                ALUSrcB = 2'd2;
                next    = dec_next;
            end
            EXEC_R: begin
                ALUSrcA   = 1'b1;
                Operation = Funct == 4'b1000 ? 4'b0110 :
                            Funct == 4'b0111 ? 4'b0000 :
                            Funct == 4'b0110 ? 4'b0001 : 4'b0010;
                next      = ALU_WB;
            end
            EXEC_I: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'd2;
                Operation = Funct[2:0] == 3'b111 ? 4'b0000 :
                            Funct[2:0] == 3'b110 ? 4'b0001 : 4'b0010;
                next      = ALU_WB;
            end
            ALU_WB: begin
                RegWrite = 1'b1;
                next     = FETCH;
            end
            MEM_ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'd2;
                next    = is_store ? MEM_WR : MEM_RD;
            end
            MEM_RD: begin
                MemRead = 1'b1;
                next    = mem_done ? MEM_WB : MEM_RD;
            end
            MEM_WB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
                next     = FETCH;
            end
            MEM_WR: begin
                MemWrite = 1'b1;
                next     = mem_done ? FETCH : MEM_WR;
            end
            BRANCH: begin
                ALUSrcA   = 1'b1;
                PCSource  = 1'b1;
                Operation = 4'b0110;
                PCWrite   = Zero;
                next      = FETCH;
            end
            default: next = IDLE;
        endcase
    end

    // Opcode is only valid in DECODE, so the load/store choice is latched for MEM_ADDR.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            wait_cnt    <= 4'd0;
            is_store    <= 1'b0;
            illegal     <= 1'b0;
            instr_count <= '0;
        end else begin
            state    <= next;
            wait_cnt <= next != state ? 4'd0 : wait_cnt + 4'd1;
            if (state == DECODE) is_store <= Opcode[5];
            if (state == DECODE && next == FETCH) illegal <= 1'b1;
            if (retire) instr_count <= instr_count + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed checks of the multicycle control FSM with MEM_LAT=1 (4-bit counter) and MEM_LAT=3.
module tb_multicycle_control;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] opcode = 7'd0;
    logic [3:0] funct = 4'd0;
    logic       zero = 1'b0;

    logic pcw1, irw1, mr1, mw1, mtr1, rw1, sa1, ps1, ill1;
    logic [1:0] sb1;
    logic [3:0] op1, cnt1;
    logic pcw3, irw3, mr3, mw3, mtr3, rw3, sa3, ps3, ill3;
    logic [1:0] sb3;
    logic [3:0] op3;
    logic [15:0] cnt3;
    logic [13:0] ctl1, ctl3;

    int checks = 0;
    int errors = 0;

    // {PCWrite,IRWrite,MemRead,MemWrite,MemtoReg,RegWrite,ALUSrcA}_ALUSrcB_PCSource_Operation
    localparam logic [13:0] V_IDLE = 14'b0000000_00_0_0010;
    localparam logic [13:0] V_F    = 14'b0010000_01_0_0010;
    localparam logic [13:0] V_FL   = 14'b1110000_01_0_0010;
    localparam logic [13:0] V_DEC  = 14'b0000000_10_0_0010;
    localparam logic [13:0] V_ADD  = 14'b0000001_00_0_0010;
    localparam logic [13:0] V_SUB  = 14'b0000001_00_0_0110;
    localparam logic [13:0] V_AND  = 14'b0000001_00_0_0000;
    localparam logic [13:0] V_OR   = 14'b0000001_00_0_0001;
    localparam logic [13:0] V_IADD = 14'b0000001_10_0_0010;
    localparam logic [13:0] V_IAND = 14'b0000001_10_0_0000;
    localparam logic [13:0] V_IOR  = 14'b0000001_10_0_0001;
    localparam logic [13:0] V_AWB  = 14'b0000010_00_0_0010;
    localparam logic [13:0] V_RD   = 14'b0010000_00_0_0010;
    localparam logic [13:0] V_MWB  = 14'b0000110_00_0_0010;
    localparam logic [13:0] V_WR   = 14'b0001000_00_0_0010;
    localparam logic [13:0] V_BT   = 14'b1000001_00_1_0110;
    localparam logic [13:0] V_BN   = 14'b0000001_00_1_0110;

    assign ctl1 = {pcw1, irw1, mr1, mw1, mtr1, rw1, sa1, sb1, ps1, op1};
    assign ctl3 = {pcw3, irw3, mr3, mw3, mtr3, rw3, sa3, sb3, ps3, op3};

    multicycle_control #(.MEM_LAT(1), .CNT_W(4)) d1 (
        .clk(clk), .reset(reset), .Opcode(opcode), .Funct(funct), .Zero(zero),
        .PCWrite(pcw1), .IRWrite(irw1), .MemRead(mr1), .MemWrite(mw1), .MemtoReg(mtr1),
        .RegWrite(rw1), .ALUSrcA(sa1), .ALUSrcB(sb1), .PCSource(ps1), .Operation(op1),
        .illegal(ill1), .instr_count(cnt1)
    );

    multicycle_control #(.MEM_LAT(3), .CNT_W(16)) d3 (
        .clk(clk), .reset(reset), .Opcode(opcode), .Funct(funct), .Zero(zero),
        .PCWrite(pcw3), .IRWrite(irw3), .MemRead(mr3), .MemWrite(mw3), .MemtoReg(mtr3),
        .RegWrite(rw3), .ALUSrcA(sa3), .ALUSrcB(sb3), .PCSource(ps3), .Operation(op3),
        .illegal(ill3), .instr_count(cnt3)
    );

    always #5 clk = ~clk;

    // Each instruction task starts and ends on a negedge in the first FETCH cycle.
    task automatic do_reset();
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        #1 reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (ctl1 !== V_IDLE) begin errors++; $display("FAIL reset_ctl1 got=%b exp=%b", ctl1, V_IDLE); end
        checks++; if (ctl3 !== V_IDLE) begin errors++; $display("FAIL reset_ctl3 got=%b exp=%b", ctl3, V_IDLE); end
        checks++; if (cnt1 !== 4'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", cnt1); end
        checks++; if (ill1 !== 1'b0) begin errors++; $display("FAIL reset_illegal got=%b exp=0", ill1); end
        reset = 1'b1;
        @(negedge clk);
        checks++; if (ctl1 !== V_FL) begin errors++; $display("FAIL first_fetch1 got=%b exp=%b", ctl1, V_FL); end
        checks++; if (ctl3 !== V_F) begin errors++; $display("FAIL first_fetch3 got=%b exp=%b", ctl3, V_F); end
    endtask

    task automatic test_add();
        logic [13:0] e [4] = '{V_FL, V_DEC, V_ADD, V_AWB};
        opcode = 7'b0110011; funct = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            checks++; if (ctl1 !== e[i]) begin errors++; $display("FAIL add cyc%0d got=%b exp=%b", i, ctl1, e[i]); end
        end
        @(negedge clk);
        checks++; if (cnt1 !== 4'd1) begin errors++; $display("FAIL add_count got=%0d exp=1", cnt1); end
    endtask

    task automatic test_alu_ops();
        logic [6:0]  oc [6] = '{7'b0110011, 7'b0110011, 7'b0110011, 7'b0010011, 7'b0010011, 7'b0010011};
        logic [3:0]  fn [6] = '{4'b1000, 4'b0111, 4'b0110, 4'b0000, 4'b1111, 4'b0110};
        logic [13:0] ex [6] = '{V_SUB, V_AND, V_OR, V_IADD, V_IAND, V_IOR};
        logic [13:0] e;
        for (int j = 0; j < 6; j++) begin
            opcode = oc[j]; funct = fn[j];
            for (int i = 0; i < 4; i++) begin
                if (i > 0) @(negedge clk);
                e = i == 0 ? V_FL : i == 1 ? V_DEC : i == 2 ? ex[j] : V_AWB;
                checks++; if (ctl1 !== e) begin errors++; $display("FAIL alu%0d cyc%0d got=%b exp=%b", j, i, ctl1, e); end
            end
            @(negedge clk);
            checks++; if (cnt1 !== 4'(2 + j)) begin errors++; $display("FAIL alu%0d_count got=%0d exp=%0d", j, cnt1, 2 + j); end
        end
    endtask

    task automatic test_beq();
        logic [13:0] e;
        opcode = 7'b1100011;
        for (int j = 0; j < 2; j++) begin
            zero = j == 0;
            for (int i = 0; i < 3; i++) begin
                if (i > 0) @(negedge clk);
                e = i == 0 ? V_FL : i == 1 ? V_DEC : (j == 0 ? V_BT : V_BN);
                checks++; if (ctl1 !== e) begin errors++; $display("FAIL beq%0d cyc%0d got=%b exp=%b", j, i, ctl1, e); end
            end
            @(negedge clk);
            checks++; if (cnt1 !== 4'(8 + j)) begin errors++; $display("FAIL beq%0d_count got=%0d exp=%0d", j, cnt1, 8 + j); end
        end
        zero = 1'b0;
    endtask

    task automatic test_sw();
        logic [13:0] e [4] = '{V_FL, V_DEC, V_IADD, V_WR};
        opcode = 7'b0100011;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            checks++; if (ctl1 !== e[i]) begin errors++; $display("FAIL sw cyc%0d got=%b exp=%b", i, ctl1, e[i]); end
        end
        @(negedge clk);
        checks++; if (cnt1 !== 4'd10) begin errors++; $display("FAIL sw_count got=%0d exp=10", cnt1); end
    endtask

    task automatic test_illegal();
        opcode = 7'b1111111;
        checks++; if (ctl1 !== V_FL) begin errors++; $display("FAIL ill_fetch got=%b exp=%b", ctl1, V_FL); end
        @(negedge clk);
        checks++; if (ctl1 !== V_DEC) begin errors++; $display("FAIL ill_decode got=%b exp=%b", ctl1, V_DEC); end
        checks++; if (ill1 !== 1'b0) begin errors++; $display("FAIL ill_before got=%b exp=0", ill1); end
        @(negedge clk);
        checks++; if (ctl1 !== V_FL) begin errors++; $display("FAIL ill_refetch got=%b exp=%b", ctl1, V_FL); end
        checks++; if (ill1 !== 1'b1) begin errors++; $display("FAIL ill_set got=%b exp=1", ill1); end
        checks++; if (cnt1 !== 4'd10) begin errors++; $display("FAIL ill_count got=%0d exp=10", cnt1); end
        opcode = 7'b0110011; funct = 4'b0001;
        @(negedge clk);
        checks++; if (ctl1 !== V_DEC) begin errors++; $display("FAIL illf_decode got=%b exp=%b", ctl1, V_DEC); end
        @(negedge clk);
        checks++; if (ctl1 !== V_FL) begin errors++; $display("FAIL illf_refetch got=%b exp=%b", ctl1, V_FL); end
        checks++; if (cnt1 !== 4'd10) begin errors++; $display("FAIL illf_count got=%0d exp=10", cnt1); end
        funct = 4'b0000;
        repeat (4) @(negedge clk);
        checks++; if (cnt1 !== 4'd11) begin errors++; $display("FAIL ill_legal_count got=%0d exp=11", cnt1); end
        checks++; if (ill1 !== 1'b1) begin errors++; $display("FAIL ill_sticky got=%b exp=1", ill1); end
    endtask

    task automatic test_wrap();
        opcode = 7'b0110011; funct = 4'b0000;
        repeat (16) @(negedge clk);
        checks++; if (cnt1 !== 4'd15) begin errors++; $display("FAIL wrap_max got=%0d exp=15", cnt1); end
        repeat (4) @(negedge clk);
        checks++; if (cnt1 !== 4'd0) begin errors++; $display("FAIL wrap_zero got=%0d exp=0", cnt1); end
    endtask

    task automatic test_lw();
        logic [13:0] e [9] = '{V_F, V_F, V_FL, V_DEC, V_IADD, V_RD, V_RD, V_RD, V_MWB};
        do_reset();
        checks++; if (ill1 !== 1'b0) begin errors++; $display("FAIL lw_ill_cleared got=%b exp=0", ill1); end
        opcode = 7'b0000011;
        for (int i = 0; i < 9; i++) begin
            if (i > 0) @(negedge clk);
            checks++; if (ctl3 !== e[i]) begin errors++; $display("FAIL lw cyc%0d got=%b exp=%b", i, ctl3, e[i]); end
        end
        @(negedge clk);
        checks++; if (ctl3 !== V_F) begin errors++; $display("FAIL lw_refetch got=%b exp=%b", ctl3, V_F); end
        checks++; if (cnt3 !== 16'd1) begin errors++; $display("FAIL lw_count got=%0d exp=1", cnt3); end
    endtask

    task automatic test_reset_mid();
        opcode = 7'b0000011;
        repeat (5) @(negedge clk);
        checks++; if (ctl3 !== V_RD) begin errors++; $display("FAIL mid_in_rd got=%b exp=%b", ctl3, V_RD); end
        reset = 1'b0;
        #1;
        checks++; if (ctl3 !== V_IDLE) begin errors++; $display("FAIL mid_async got=%b exp=%b", ctl3, V_IDLE); end
        checks++; if (cnt3 !== 16'd0) begin errors++; $display("FAIL mid_count got=%0d exp=0", cnt3); end
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++; if (ctl3 !== V_IDLE) begin errors++; $display("FAIL mid_release got=%b exp=%b", ctl3, V_IDLE); end
        @(negedge clk);
        checks++; if (ctl3 !== V_F) begin errors++; $display("FAIL mid_fetch got=%b exp=%b", ctl3, V_F); end
        checks++; if (cnt3 !== 16'd0) begin errors++; $display("FAIL mid_count2 got=%0d exp=0", cnt3); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_alu_ops();
        test_beq();
        test_sw();
        test_illegal();
        test_wrap();
        test_lw();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
